// File: rtl/qpsk_pkg.sv
// Shared QPSK/BPSK definitions: mode constants, FSM states, symbol payload and
// the symbol-to-phase-offset mapping used by the modulator and the demodulator.
package qpsk_pkg;

  localparam logic MODE_QPSK = 1'b0;
  localparam logic MODE_BPSK = 1'b1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  typedef struct packed {
    logic odd;
    logic even;
  } sym_t;

  // Starting LUT index for a symbol; BPSK only looks at the even bit
  function automatic int unsigned phase_offset(input sym_t bits, input logic mode,
                                               input int unsigned lut_depth);
    int unsigned quarter;
    int unsigned offset;
    quarter = lut_depth / 4;
    offset  = 0;
    if (mode == MODE_BPSK) begin
      offset = bits.even ? 2 * quarter : 0;
    end else begin
      case ({bits.odd, bits.even})
        2'b00:   offset = 0;
        2'b01:   offset = quarter;
        2'b10:   offset = 2 * quarter;
        default: offset = 3 * quarter;
      endcase
    end
    return offset;
  endfunction

endpackage

// File: rtl/qpsk_mod_param_if.sv
// Symbol-in / sample-out bundle of the carrier modulator.
interface qpsk_mod_param_if #(
  parameter int unsigned DATA_W = 11
) ();

  logic                     enable;
  logic                     mode;
  logic                     sym_valid;
  logic [1:0]               sym_bits;
  logic                     sym_ready;
  logic signed [DATA_W-1:0] data_out;
  logic                     out_valid;
  logic                     sym_start;
  logic                     underrun;

  modport master (
    output enable,
    output mode,
    output sym_valid,
    output sym_bits,
    input  sym_ready,
    input  data_out,
    input  out_valid,
    input  sym_start,
    input  underrun
  );

  modport slave (
    input  enable,
    input  mode,
    input  sym_valid,
    input  sym_bits,
    output sym_ready,
    output data_out,
    output out_valid,
    output sym_start,
    output underrun
  );

endinterface

// File: rtl/sine_rom.sv
// One-period signed sine table, contents fixed at elaboration; combinational read.
module sine_rom #(
  parameter int unsigned DATA_W    = 11,
  parameter int unsigned LUT_DEPTH = 100,
  parameter int unsigned AMPL      = 1000,
  localparam int unsigned ADDR_W   = $clog2(LUT_DEPTH)
) (
  input  logic [ADDR_W-1:0]        addr,
  output logic signed [DATA_W-1:0] sample_c
);

  localparam real PI = 3.14159265358979323846;

  // round(AMPL*sin(2*pi*k/LUT_DEPTH)); Taylor series over [-pi, pi] keeps it tool-portable
  function automatic int sine_entry(input int unsigned k);
    real x;
    real term;
    real sum;
    real y;
    x = 2.0 * PI * real'(k) / real'(LUT_DEPTH);
    if (x > PI) x = x - 2.0 * PI;
    term = x;
    sum  = x;
    for (int n = 1; n <= 12; n++) begin
      term = -term * x * x / real'((2 * n) * (2 * n + 1));
      sum  = sum + term;
    end
    y = real'(AMPL) * sum;
    return (y >= 0.0) ? $rtoi(y + 0.5) : $rtoi(y - 0.5);
  endfunction

  logic signed [DATA_W-1:0] rom [LUT_DEPTH];

  for (genvar k = 0; k < LUT_DEPTH; k++) begin : g_rom
    localparam logic signed [DATA_W-1:0] ENTRY = DATA_W'(sine_entry(k));
    assign rom[k] = ENTRY;
  end

  assign sample_c = rom[addr];

endmodule

// File: rtl/qpsk_mod_param.sv
// QPSK/BPSK carrier modulator: one-entry symbol buffer feeding a phase-offset
// sine generator that emits SYM_SAMPLES samples per symbol with underrun reporting.
module qpsk_mod_param
  import qpsk_pkg::*;
#(
  parameter int unsigned DATA_W      = 11,
  parameter int unsigned LUT_DEPTH   = 100,
  parameter int unsigned AMPL        = 1000,
  parameter int unsigned SYM_SAMPLES = 100
) (
  input logic             clk,
  input logic             rst,
  qpsk_mod_param_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(LUT_DEPTH);
  localparam int unsigned CNT_W = $clog2(SYM_SAMPLES);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(LUT_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SYM_SAMPLES - 1);

  state_e                   state_q, state_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     buf_full_q, buf_full_d;
  sym_t                     buf_sym_q, buf_sym_d;
  logic signed [DATA_W-1:0] data_q, data_d;
  logic                     valid_q, valid_d;
  logic                     start_q, start_d;
  logic                     under_q, under_d;

  logic signed [DATA_W-1:0] lut_c;
  logic                     accept_c;
  logic                     last_c;
  logic [IDX_W-1:0]         load_idx_c;

  sine_rom #(
    .DATA_W    (DATA_W),
    .LUT_DEPTH (LUT_DEPTH),
    .AMPL      (AMPL)
  ) u_rom (
    .addr     (idx_q),
    .sample_c (lut_c)
  );

  assign accept_c   = bus.sym_valid & ~buf_full_q;
  assign last_c     = (cnt_q == CNT_LAST);
  // mode is taken at load time, not at accept time
  assign load_idx_c = IDX_W'(phase_offset(buf_sym_q, bus.mode, LUT_DEPTH));

  // Next-state and output decode
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    buf_full_d = buf_full_q;
    buf_sym_d  = buf_sym_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    start_d    = 1'b0;
    under_d    = 1'b0;

    // Accepts proceed even while the generator is frozen
    if (accept_c) begin
      buf_full_d = 1'b1;
      buf_sym_d  = sym_t'(bus.sym_bits);
    end

    if (bus.enable) begin
      case (state_q)
        IDLE: begin
          data_d = '0;
          if (buf_full_q) begin
            idx_d      = load_idx_c;
            cnt_d      = '0;
            buf_full_d = 1'b0;
            state_d    = RUN;
          end
        end
        RUN: begin
          data_d  = lut_c;
          valid_d = 1'b1;
          start_d = (cnt_q == '0);
          idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
          cnt_d   = cnt_q + CNT_W'(1);
          if (last_c) begin
            cnt_d = '0;
            // A waiting symbol restarts the phase with no output gap
            if (buf_full_q) begin
              idx_d      = load_idx_c;
              buf_full_d = 1'b0;
            end else begin
              under_d = 1'b1;
              state_d = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      cnt_q      <= '0;
      buf_full_q <= 1'b0;
      buf_sym_q  <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      start_q    <= 1'b0;
      under_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      buf_full_q <= buf_full_d;
      buf_sym_q  <= buf_sym_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      start_q    <= start_d;
      under_q    <= under_d;
    end
  end

  assign bus.sym_ready = ~buf_full_q;
  assign bus.data_out  = data_q;
  assign bus.out_valid = valid_q;
  assign bus.sym_start = start_q;
  assign bus.underrun  = under_q;

endmodule

// File: tb/tb_qpsk_mod_param.sv
// Bench for qpsk_mod_param: a default instance and a short-table instance
// (LUT_DEPTH 8, SYM_SAMPLES 12, AMPL 100) share stimulus and are scored against a sine model.
module tb_qpsk_mod_param;

  localparam int NI = 2;
  localparam int DW = 11;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       mode = 1'b0;
  logic       sym_valid = 1'b0;
  logic [1:0] sym_bits = 2'b00;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  qpsk_mod_param_if #(.DATA_W(DW)) bus0 ();
  qpsk_mod_param_if #(.DATA_W(DW)) bus1 ();

  assign bus0.enable = enable;    assign bus1.enable = enable;
  assign bus0.mode = mode;        assign bus1.mode = mode;
  assign bus0.sym_valid = sym_valid; assign bus1.sym_valid = sym_valid;
  assign bus0.sym_bits = sym_bits;   assign bus1.sym_bits = sym_bits;

  qpsk_mod_param #(.DATA_W(DW)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  qpsk_mod_param #(.DATA_W(DW), .LUT_DEPTH(8), .AMPL(100), .SYM_SAMPLES(12))
    dut1 (.clk(clk), .rst(rst), .bus(bus1));

  logic signed [DW-1:0] dout [NI];
  logic vld [NI], sst [NI], und [NI], rdy [NI];
  assign dout[0] = bus0.data_out;  assign dout[1] = bus1.data_out;
  assign vld[0]  = bus0.out_valid; assign vld[1]  = bus1.out_valid;
  assign sst[0]  = bus0.sym_start; assign sst[1]  = bus1.sym_start;
  assign und[0]  = bus0.underrun;  assign und[1]  = bus1.underrun;
  assign rdy[0]  = bus0.sym_ready; assign rdy[1]  = bus1.sym_ready;

  function automatic int lut_len(input int i); return (i == 0) ? 100 : 8;  endfunction
  function automatic int sym_len(input int i); return (i == 0) ? 100 : 12; endfunction
  function automatic int amp(input int i);     return (i == 0) ? 1000 : 100; endfunction

  function automatic int sine_ref(input int i, input int k);
    real y;
    y = real'(amp(i)) * $sin(2.0 * 3.14159265358979 * real'(k % lut_len(i)) / real'(lut_len(i)));
    return (y >= 0.0) ? $rtoi(y + 0.5) : $rtoi(y - 0.5);
  endfunction

  // Model: one-slot buffer, position within the current symbol, phase offset
  bit m_full [NI];
  int m_bits [NI];
  bit m_busy [NI];
  int m_pos  [NI];
  int m_off  [NI];
  int e_data [NI];
  bit e_vld  [NI];
  bit e_sst  [NI];
  bit e_und  [NI];

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      m_full[i] = 0; m_bits[i] = 0; m_busy[i] = 0; m_pos[i] = 0; m_off[i] = 0;
      e_data[i] = 0; e_vld[i] = 0; e_sst[i] = 0; e_und[i] = 0;
    end
  endtask

  task automatic model_load(input int i);
    m_off[i]  = mode ? (m_bits[i] % 2) * (lut_len(i) / 2) : m_bits[i] * (lut_len(i) / 4);
    m_pos[i]  = 0;
    m_busy[i] = 1;
    m_full[i] = 0;
  endtask

  always @(posedge clk) begin
    if (rst) begin
      model_reset();
    end else begin
      for (int i = 0; i < NI; i++) begin
        bit acc;
        acc = sym_valid && !m_full[i];
        e_vld[i] = 0; e_sst[i] = 0; e_und[i] = 0;
        if (enable) begin
          if (!m_busy[i]) begin
            e_data[i] = 0;
            if (m_full[i]) model_load(i);
          end else begin
            e_data[i] = sine_ref(i, m_off[i] + m_pos[i]);
            e_vld[i]  = 1;
            e_sst[i]  = (m_pos[i] == 0);
            m_pos[i]++;
            if (m_pos[i] == sym_len(i)) begin
              if (m_full[i]) model_load(i);
              else begin
                m_busy[i] = 0;
                e_und[i]  = 1;
              end
            end
          end
        end
        if (acc) begin
          m_full[i] = 1;
          m_bits[i] = int'(sym_bits);
        end
      end
    end
  end

  task automatic check(input string tag, input int got, input int want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%0d want=%0d at %0t", tag, got, want, $time);
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < NI; i++) begin
      check($sformatf("data_out[%0d]", i),  int'(dout[i]), e_data[i]);
      check($sformatf("out_valid[%0d]", i), int'(vld[i]),  int'(e_vld[i]));
      check($sformatf("sym_start[%0d]", i), int'(sst[i]),  int'(e_sst[i]));
      check($sformatf("underrun[%0d]", i),  int'(und[i]),  int'(e_und[i]));
      check($sformatf("sym_ready[%0d]", i), int'(rdy[i]),  int'(!m_full[i]));
    end
  endtask

  task automatic cycle(input bit en, input bit md, input bit v, input logic [1:0] b);
    @(negedge clk);
    compare_all();
    enable = en; mode = md; sym_valid = v; sym_bits = b;
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    compare_all();
    rst = 1'b0;

    // Single QPSK symbol 00 followed by underrun and idle
    cycle(1, 0, 1, 2'b00);
    repeat (130) cycle(1, 0, 0, 2'b00);

    // Back-to-back 11 then 01 with valid held
    for (int c = 0; c < 260; c++) cycle(1, 0, 1, (c < 100) ? 2'b11 : 2'b01);
    repeat (120) cycle(1, 0, 0, 2'b00);

    // BPSK: odd bit ignored, phase 0 or half period
    for (int c = 0; c < 260; c++) cycle(1, 1, 1, (c < 110) ? 2'b10 : 2'b01);
    repeat (120) cycle(1, 1, 0, 2'b00);

    // Random enable gaps, modes, symbols and offer pattern
    for (int c = 0; c < 3000; c++) begin
      cycle($urandom_range(9) < 8, 1'($urandom_range(1)),
            $urandom_range(3) != 0, 2'($urandom_range(3)));
    end
    repeat (150) cycle(1, 0, 0, 2'b00);

    // Asynchronous reset mid-symbol with the buffer refilled
    repeat (40) cycle(1, 0, 1, 2'($urandom_range(3)));
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    for (int i = 0; i < NI; i++) begin
      check($sformatf("async_rst_data[%0d]", i),  int'(dout[i]), 0);
      check($sformatf("async_rst_valid[%0d]", i), int'(vld[i]),  0);
      check($sformatf("async_rst_ready[%0d]", i), int'(rdy[i]),  1);
    end
    model_reset();
    repeat (2) cycle(1, 0, 0, 2'b00);
    rst = 1'b0;
    repeat (30) cycle(1, 0, 0, 2'b00);
    cycle(1, 0, 1, 2'b10);
    repeat (140) cycle(1, 0, 0, 2'b00);
    @(negedge clk);
    compare_all();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
